// File: rtl/ee354_numlock_pkg.sv
// rtl/ee354_numlock_pkg.sv - shared state encoding and sizing helpers for the number lock
package ee354_numlock_pkg;

    // Bit positions of each state inside the one-hot q_state vector
    localparam int ST_I_BIT       = 0;
    localparam int ST_WAIT_BIT    = 1;
    localparam int ST_GET_BIT     = 2;
    localparam int ST_OPENING_BIT = 3;
    localparam int ST_BAD_BIT     = 4;
    localparam int ST_LOCKOUT_BIT = 5;
    localparam int ST_PROG_BIT    = 6;
    localparam int NUM_STATES     = 7;

    typedef enum logic [NUM_STATES-1:0] {
        ST_I       = 7'b0000001,
        ST_WAIT    = 7'b0000010,
        ST_GET     = 7'b0000100,
        ST_OPENING = 7'b0001000,
        ST_BAD     = 7'b0010000,
        ST_LOCKOUT = 7'b0100000,
        ST_PROG    = 7'b1000000
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ee354_numlock_timer.sv
// rtl/ee354_numlock_timer.sv - loadable down-counter shared by the open and lockout windows
module ee354_numlock_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ee354_numlock_param.sv
// rtl/ee354_numlock_param.sv - programmable CODE_LEN-digit number lock with failed-attempt lockout
module ee354_numlock_param
    import ee354_numlock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE_INIT      = 4'b1011,
    parameter int                  OPEN_CYCLES    = 16,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 64
) (
    input  logic                              Clk,
    input  logic                              reset,
    input  logic                              U,
    input  logic                              Z,
    input  logic                              Prog,
    output logic                              Unlock,
    output logic                              Locked,
    output logic [NUM_STATES-1:0]             q_state,
    output logic [clog2(CODE_LEN)-1:0]        digit_idx,
    output logic [clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

    localparam int IDX_W  = clog2(CODE_LEN);
    localparam int FAIL_W = clog2(MAX_FAIL + 1);
    localparam int TMR_W  = clog2(max2(OPEN_CYCLES, LOCKOUT_CYCLES));

    state_t              state;
    logic [CODE_LEN-1:0] code;
    logic                prog_held;

    logic                press_any;
    logic                press_valid;
    logic                last_digit;
    logic [IDX_W-1:0]    bit_sel;
    logic                expected_digit;
    logic [FAIL_W-1:0]   fail_next;
    logic                timer_load;
    logic [TMR_W-1:0]    timer_value;
    logic                timer_zero;

    // Digits are entered MSB first, so digit_idx 0 addresses the top code bit
    assign press_any      = U | Z;
    assign press_valid    = U ^ Z;
    assign last_digit     = (digit_idx == IDX_W'(CODE_LEN - 1));
    assign bit_sel        = IDX_W'(CODE_LEN - 1) - digit_idx;
    assign expected_digit = code[bit_sel];
    assign fail_next      = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    // Timer is loaded on the release edge that enters OPENING or LOCKOUT
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TMR_W'(LOCKOUT_CYCLES - 1);
        if (state == ST_GET && !press_any && last_digit) begin
            timer_load  = 1'b1;
            timer_value = TMR_W'(OPEN_CYCLES - 1);
        end
        if (state == ST_BAD && !press_any && fail_next == FAIL_W'(MAX_FAIL)) begin
            timer_load = 1'b1;
        end
    end

    ee354_numlock_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk   (Clk),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    // Lock state machine together with the code register, digit index and failure count
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= ST_I;
            digit_idx <= '0;
            fail_cnt  <= '0;
            code      <= CODE_INIT;
            prog_held <= 1'b0;
        end else begin
            case (state)
                ST_I, ST_WAIT: begin
                    if (press_any) begin
                        if (press_valid && (U == expected_digit)) begin
                            state <= ST_GET;
                        end else begin
                            state <= ST_BAD;
                        end
                    end
                end
                ST_GET: begin
                    if (!press_any) begin
                        if (last_digit) begin
                            state     <= ST_OPENING;
                            digit_idx <= '0;
                            fail_cnt  <= '0;
                        end else begin
                            state     <= ST_WAIT;
                            digit_idx <= digit_idx + 1'b1;
                        end
                    end
                end
                ST_BAD: begin
                    if (!press_any) begin
                        digit_idx <= '0;
                        fail_cnt  <= fail_next;
                        state     <= (fail_next == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_I;
                    end
                end
                ST_OPENING: begin
                    if (Prog) begin
                        state     <= ST_PROG;
                        digit_idx <= '0;
                        prog_held <= 1'b0;
                    end else if (timer_zero) begin
                        state <= ST_I;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_zero) begin
                        state    <= ST_I;
                        fail_cnt <= '0;
                    end
                end
                ST_PROG: begin
                    // Write on the press edge; advance only once both buttons are released
                    if (!prog_held) begin
                        if (press_valid) begin
                            code[bit_sel] <= U;
                            prog_held     <= 1'b1;
                        end
                    end else if (!press_any) begin
                        prog_held <= 1'b0;
                        if (last_digit) begin
                            state     <= ST_I;
                            digit_idx <= '0;
                        end else begin
                            digit_idx <= digit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_I;
                end
            endcase
        end
    end

    assign q_state = state;
    assign Unlock  = state[ST_OPENING_BIT];
    assign Locked  = state[ST_LOCKOUT_BIT];

endmodule

// File: tb/tb_ee354_numlock_param.sv
// tb/tb_ee354_numlock_param.sv - self-checking bench for the parametrised number lock
module tb_ee354_numlock_param;

    localparam logic [6:0] Q_I    = 7'b0000001;
    localparam logic [6:0] Q_WAIT = 7'b0000010;
    localparam logic [6:0] Q_GET  = 7'b0000100;
    localparam logic [6:0] Q_OPEN = 7'b0001000;
    localparam logic [6:0] Q_BAD  = 7'b0010000;
    localparam logic [6:0] Q_LOCK = 7'b0100000;
    localparam logic [6:0] Q_PROG = 7'b1000000;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic U = 1'b0;
    logic Z = 1'b0;
    logic Prog = 1'b0;

    logic       Unlock1, Locked1;
    logic [6:0] q_state1;
    logic [1:0] digit_idx1;
    logic [1:0] fail_cnt1;

    logic       Unlock2, Locked2;
    logic [6:0] q_state2;
    logic [2:0] digit_idx2;
    logic [0:0] fail_cnt2;

    int n_checks = 0;
    int n_pass = 0;
    bit started = 1'b0;

    int run_unlock1 = 0, last_unlock1 = 0;
    int run_locked1 = 0, last_locked1 = 0;
    int run_unlock2 = 0, last_unlock2 = 0;

    always #5 Clk = ~Clk;

    ee354_numlock_param u_dut4 (
        .Clk(Clk), .reset(reset), .U(U), .Z(Z), .Prog(Prog),
        .Unlock(Unlock1), .Locked(Locked1), .q_state(q_state1),
        .digit_idx(digit_idx1), .fail_cnt(fail_cnt1)
    );

    ee354_numlock_param #(
        .CODE_LEN(6), .CODE_INIT(6'b110010), .OPEN_CYCLES(2),
        .MAX_FAIL(1), .LOCKOUT_CYCLES(64)
    ) u_dut6 (
        .Clk(Clk), .reset(reset), .U(U), .Z(Z), .Prog(Prog),
        .Unlock(Unlock2), .Locked(Locked2), .q_state(q_state2),
        .digit_idx(digit_idx2), .fail_cnt(fail_cnt2)
    );

    // Abstract model: counts of matched digits, remaining window cycles and held-button flags
    typedef struct {
        logic [15:0] code;
        int          pos;
        int          fails;
        int          open_left;
        int          lock_left;
        bit          prog;
        bit          prog_held;
        bit          held_ok;
        bit          held_bad;
    } model_t;

    model_t m4, m6;

    function automatic model_t model_step(input model_t m, input bit rst, input bit u, input bit z,
                                          input bit pg, input int len, input logic [15:0] init,
                                          input int open_c, input int max_f, input int lock_c);
        model_t n;
        n = m;
        if (rst) begin
            n.code = init; n.pos = 0; n.fails = 0; n.open_left = 0; n.lock_left = 0;
            n.prog = 0; n.prog_held = 0; n.held_ok = 0; n.held_bad = 0;
        end else if (m.lock_left > 0) begin
            n.lock_left = m.lock_left - 1;
            if (n.lock_left == 0) n.fails = 0;
        end else if (m.open_left > 0) begin
            if (pg) begin
                n.open_left = 0; n.prog = 1; n.prog_held = 0; n.pos = 0;
            end else begin
                n.open_left = m.open_left - 1;
            end
        end else if (m.prog) begin
            if (!m.prog_held) begin
                if (u != z) begin
                    n.code[len-1-m.pos] = u;
                    n.prog_held = 1;
                end
            end else if (!u && !z) begin
                n.prog_held = 0;
                n.pos = m.pos + 1;
                if (n.pos == len) begin
                    n.pos = 0; n.prog = 0;
                end
            end
        end else if (m.held_ok) begin
            if (!u && !z) begin
                n.held_ok = 0;
                n.pos = m.pos + 1;
                if (n.pos == len) begin
                    n.pos = 0; n.fails = 0; n.open_left = open_c;
                end
            end
        end else if (m.held_bad) begin
            if (!u && !z) begin
                n.held_bad = 0;
                n.pos = 0;
                n.fails = (m.fails + 1 > max_f) ? max_f : m.fails + 1;
                if (n.fails == max_f) n.lock_left = lock_c;
            end
        end else begin
            if (u != z && u == m.code[len-1-m.pos]) n.held_ok = 1;
            else if (u || z) n.held_bad = 1;
        end
        return n;
    endfunction

    function automatic logic [6:0] model_q(input model_t m);
        if (m.lock_left > 0) return Q_LOCK;
        if (m.open_left > 0) return Q_OPEN;
        if (m.prog) return Q_PROG;
        if (m.held_bad) return Q_BAD;
        if (m.held_ok) return Q_GET;
        if (m.pos == 0) return Q_I;
        return Q_WAIT;
    endfunction

    function automatic logic [63:0] pack(input logic [6:0] q, input logic un, input logic lk,
                                         input logic [15:0] idx, input logic [7:0] f);
        return {31'd0, q, un, lk, idx, f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model advances on the same edge as the DUTs, using the inputs sampled there
    always @(posedge Clk) begin
        m4 = model_step(m4, reset, U, Z, Prog, 4, 16'h000B, 16, 3, 64);
        m6 = model_step(m6, reset, U, Z, Prog, 6, 16'h0032, 2, 1, 64);
        if (reset) started = 1'b1;
    end

    // Every cycle after the first reset edge both DUTs must match the model
    always @(negedge Clk) begin
        if (started) begin
            check("model_dut4",
                  pack(q_state1, Unlock1, Locked1, 16'(digit_idx1), 8'(fail_cnt1)),
                  pack(model_q(m4), m4.open_left > 0, m4.lock_left > 0, 16'(m4.pos), 8'(m4.fails)));
            check("model_dut6",
                  pack(q_state2, Unlock2, Locked2, 16'(digit_idx2), 8'(fail_cnt2)),
                  pack(model_q(m6), m6.open_left > 0, m6.lock_left > 0, 16'(m6.pos), 8'(m6.fails)));
        end
    end

    // Length of the most recent Unlock / Locked high run
    always @(negedge Clk) begin
        if (Unlock1 === 1'b1) run_unlock1++;
        else if (run_unlock1 != 0) begin last_unlock1 = run_unlock1; run_unlock1 = 0; end
        if (Locked1 === 1'b1) run_locked1++;
        else if (run_locked1 != 0) begin last_locked1 = run_locked1; run_locked1 = 0; end
        if (Unlock2 === 1'b1) run_unlock2++;
        else if (run_unlock2 != 0) begin last_unlock2 = run_unlock2; run_unlock2 = 0; end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
    endtask

    task automatic press_begin(input logic u, input logic z);
        @(negedge Clk);
        U = u;
        Z = z;
        #100;
    endtask

    task automatic press_end();
        U = 1'b0;
        Z = 1'b0;
        #50;
    endtask

    task automatic press(input logic d);
        press_begin(d, !d);
        press_end();
    endtask

    task automatic enter(input logic [15:0] c, input int n);
        for (int i = n - 1; i >= 0; i--) press(c[i]);
    endtask

    int         exp_idx[4] = '{1, 2, 3, 0};
    logic [6:0] exp_q_entry[4] = '{Q_WAIT, Q_WAIT, Q_WAIT, Q_OPEN};
    logic [6:0] exp_q_prog[4] = '{Q_PROG, Q_PROG, Q_PROG, Q_I};
    logic [3:0] code_1011 = 4'b1011;
    logic [3:0] code_0110 = 4'b0110;

    initial begin
        // Reset state
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        check("reset_q", 64'(q_state1), 64'(Q_I));
        check("reset_outs", {60'd0, Unlock1, Locked1, digit_idx1 | fail_cnt1}, 64'd0);

        // Correct code 1011
        for (int i = 0; i < 4; i++) begin
            press(code_1011[3-i]);
            check("entry_idx", 64'(digit_idx1), 64'(exp_idx[i]));
            check("entry_q", 64'(q_state1), 64'(exp_q_entry[i]));
        end
        idle(20);
        check("open_len", 64'(last_unlock1), 64'd16);
        check("after_open_q", 64'(q_state1), 64'(Q_I));
        check("after_open_fail", 64'(fail_cnt1), 64'd0);

        // Wrong digit and U&Z in WAIT
        press(1'b1);
        press(1'b0);
        press_begin(1'b0, 1'b1);
        check("wrong_bad_q", 64'(q_state1), 64'(Q_BAD));
        press_end();
        check("wrong_fail", 64'(fail_cnt1), 64'd1);
        check("wrong_idx", 64'(digit_idx1), 64'd0);
        check("wrong_q", 64'(q_state1), 64'(Q_I));
        press(1'b1);
        press_begin(1'b1, 1'b1);
        check("both_bad_q", 64'(q_state1), 64'(Q_BAD));
        press_end();
        check("both_fail", 64'(fail_cnt1), 64'd2);

        // Lockout after three bad attempts; a correct code during lockout is ignored
        do_reset();
        repeat (3) press(1'b0);
        check("lock_q", 64'(q_state1), 64'(Q_LOCK));
        check("lock_fail", 64'(fail_cnt1), 64'd3);
        enter(16'(code_1011), 4);
        idle(20);
        check("lock_len", 64'(last_locked1), 64'd64);
        check("lock_exit_q", 64'(q_state1), 64'(Q_I));
        check("lock_exit_fail", 64'(fail_cnt1), 64'd0);

        // Reprogram to 0110
        do_reset();
        enter(16'(code_1011), 4);
        @(negedge Clk);
        Prog = 1'b1;
        @(negedge Clk);
        Prog = 1'b0;
        check("prog_q", 64'(q_state1), 64'(Q_PROG));
        check("prog_unlock", 64'(Unlock1), 64'd0);
        for (int i = 0; i < 4; i++) begin
            press(code_0110[3-i]);
            check("prog_idx", 64'(digit_idx1), 64'(exp_idx[i]));
            check("prog_step_q", 64'(q_state1), 64'(exp_q_prog[i]));
        end
        press(1'b1);
        check("old_code_fail", 64'(fail_cnt1), 64'd1);
        enter(16'(code_0110), 4);
        check("new_code_open", 64'(q_state1), 64'(Q_OPEN));
        idle(20);
        do_reset();
        enter(16'(code_1011), 4);
        check("restored_open", 64'(q_state1), 64'(Q_OPEN));
        idle(20);

        // Reset during GET of the last digit
        do_reset();
        enter(16'(3'b101), 3);
        press_begin(1'b1, 1'b0);
        check("mid_get_q", 64'(q_state1), 64'(Q_GET));
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("rst_get", {51'd0, q_state1, Unlock1, Locked1, digit_idx1, fail_cnt1}, {51'd0, Q_I, 6'd0});
        U = 1'b0;
        @(negedge Clk);
        reset = 1'b0;
        idle(3);
        enter(16'(code_1011), 4);
        check("rst_get_code", 64'(q_state1), 64'(Q_OPEN));
        idle(20);

        // Reset during PROG after two digits
        enter(16'(code_1011), 4);
        @(negedge Clk);
        Prog = 1'b1;
        @(negedge Clk);
        Prog = 1'b0;
        press(1'b0);
        press(1'b1);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        check("rst_prog", {51'd0, q_state1, Unlock1, Locked1, digit_idx1, fail_cnt1}, {51'd0, Q_I, 6'd0});
        enter(16'(code_1011), 4);
        check("rst_prog_code", 64'(q_state1), 64'(Q_OPEN));
        idle(20);

        // Six-digit instance: 2-cycle open, single failure locks out
        do_reset();
        enter(16'h0032, 6);
        check("p6_open_len", 64'(last_unlock2), 64'd2);
        check("p6_after_q", 64'(q_state2), 64'(Q_I));
        press(1'b0);
        check("p6_lock_q", 64'(q_state2), 64'(Q_LOCK));
        check("p6_locked", 64'(Locked2), 64'd1);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
